seq_shift_right: RTL and testbench



---
 rtl/seq_shift_right.sv | 82 ++++++++
 tb/tb_seq_shift_right.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_right.sv
// Multi-cycle right shifter: one bit position per clock, logical or arithmetic fill.
// The result stays on out from completion until the next accepted start.
module seq_shift_right #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] in,
   input  logic [SHW-1:0]   shamt,
   input  logic             arith,
   output logic [WIDTH-1:0] out,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic [SHW-1:0]   count, count_nx;
   logic             mode, mode_nx;
   logic [WIDTH-1:0] out_nx;
   logic             fill;

   always_comb begin
      state_nx = state;
      count_nx = count;
      mode_nx  = mode;
      out_nx   = out;
      // The MSB never changes during an arithmetic shift, so it is the original sign.
      fill     = mode & out[WIDTH-1];
      case (state)
         IDLE: begin
            if (start) begin
               out_nx   = in;
               count_nx = shamt;
               mode_nx  = arith;
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            if (count == '0) begin
               state_nx = DONE;
            end else begin
               out_nx   = {fill, out[WIDTH-1:1]};
               count_nx = count - SHW'(1);
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         count <= '0;
         mode  <= 1'b0;
         out   <= '0;
      end else begin
         state <= state_nx;
         count <= count_nx;
         mode  <= mode_nx;
         out   <= out_nx;
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   a_done_busy : assert property (@(posedge clk) disable iff (reset) done |-> busy);
   a_legal     : assert property (@(posedge clk) disable iff (reset)
                                  state inside {IDLE, SHIFT, DONE});
   a_no_under  : assert property (@(posedge clk) disable iff (reset)
                                  (state == SHIFT && count == '0) |=> state == DONE);

endmodule

// File: tb/tb_seq_shift_right.sv
// Scoreboard bench for seq_shift_right: stimulus pushes expected result and
// completion cycle, a monitor pops and compares on every done strobe.
module tb_seq_shift_right;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned SHW   = 5;

   logic             clk = 1'b0;
   logic             clk_en = 1'b1;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic [WIDTH-1:0] in = '0;
   logic [SHW-1:0]   shamt = '0;
   logic             arith = 1'b0;
   logic [WIDTH-1:0] out;
   logic             busy;
   logic             done;

   seq_shift_right #(.WIDTH(WIDTH), .SHW(SHW)) dut (
      .clk(clk), .reset(reset), .start(start), .in(in), .shamt(shamt),
      .arith(arith), .out(out), .busy(busy), .done(done)
   );

   initial forever begin
      #5;
      if (clk_en) clk = ~clk;
   end

   int unsigned cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   typedef struct {
      logic [WIDTH-1:0] res;
      int unsigned      at;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] v,
                                               input int unsigned sh, input logic ar);
      if (ar) return WIDTH'($signed(v) >>> sh);
      return v >> sh;
   endfunction

   // Monitor: completion strobes, latency, result retention, busy falling after done
   initial begin
      logic [WIDTH-1:0] last_res;
      logic             prev_done;
      exp_t             e;
      last_res  = '0;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            last_res  = '0;
            prev_done = 1'b0;
         end else begin
            if (prev_done) chk("busy_after_done", WIDTH'(busy), '0);
            if (done) begin
               chk("done_implies_busy", WIDTH'(busy), WIDTH'(1));
               if (q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done: got done with no pending job, required none (cycle %0d)", cyc);
               end else begin
                  e = q.pop_front();
                  chk("result", out, e.res);
                  chk("done_cycle", WIDTH'(cyc), WIDTH'(e.at));
                  last_res = e.res;
               end
            end else if (!busy) begin
               chk("retained_out", out, last_res);
            end
            prev_done = done;
         end
      end
   end

   task automatic issue(input logic [WIDTH-1:0] v, input int unsigned sh,
                        input logic ar, input bit hold);
      exp_t e;
      @(negedge clk);
      while (busy) @(negedge clk);
      in    = v;
      shamt = SHW'(sh);
      arith = ar;
      start = 1'b1;
      e.res = model(v, sh, ar);
      e.at  = cyc + sh + 2;
      q.push_back(e);
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
      in    = $urandom;
      shamt = SHW'($urandom);
      arith = 1'($urandom);
   endtask

   task automatic drain();
      int unsigned n;
      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout: got %0d pending jobs, required 0", q.size());
         q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      // Asynchronous reset with the clock stopped
      @(negedge clk);
      clk_en = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("reset_out", out, '0);
      chk("reset_busy", WIDTH'(busy), '0);
      chk("reset_done", WIDTH'(done), '0);
      clk_en = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      chk("idle_out", out, '0);

      issue(32'hF000_00F0, 4, 1'b0, 1'b0);
      drain();
      issue(32'h8000_0010, 31, 1'b1, 1'b0);
      drain();
      issue(32'h8000_0010, 31, 1'b0, 1'b0);
      drain();
      issue(32'h1234_5678, 0, 1'b0, 1'b0);
      drain();

      // start pulsed mid-shift must be ignored
      issue(32'hCAFE_F00D, 8, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      in    = 32'hDEAD_BEEF;
      shamt = SHW'(1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain();

      // Reset mid-operation discards the job
      issue(32'h7654_3210, 20, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      #2 reset = 1'b1;
      q.delete();
      #1;
      chk("abort_out", out, '0);
      chk("abort_busy", WIDTH'(busy), '0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (30) @(negedge clk);
      issue(32'h0000_0100, 8, 1'b0, 1'b0);
      drain();

      // Back-to-back with start held high
      issue(32'hA5A5_A5A5, 3, 1'b1, 1'b1);
      issue(32'h0F0F_0F0F, 3, 1'b0, 1'b1);
      start = 1'b0;
      drain();

      for (int i = 0; i < 30; i++) begin
         issue($urandom, $urandom_range(WIDTH - 1, 0), 1'($urandom), bit'($urandom_range(1, 0)));
      end
      start = 1'b0;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
